// File: rtl/alu_mc_if.sv
// ALU_MC bus interface: request side (start, operands, opcode) and
// result side (acc/hi, flags, busy/done). clk and rst stay plain ports.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] hi;
  logic             status;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             busy;
  logic             done;

  // Requester: drives the operation, observes results.
  modport master (
    output start, c, d, alu_control,
    input  acc, hi, status, carry, overflow, negative, busy, done
  );

  // ALU: consumes the operation, produces results.
  modport slave (
    input  start, c, d, alu_control,
    output acc, hi, status, carry, overflow, negative, busy, done
  );
endinterface

// File: rtl/alu_mc.sv
// ALU_MC: registered ALU with single-cycle arithmetic/logic/shift/compare
// ops and an optional iterative shift-add unsigned multiplier.
// Build option: define ALU_MUL_EN to include the multiplier (code 0100,
// WIDTH cycles, full 2*WIDTH product on {hi,acc}). Without it, code 0100
// decodes as add, busy never rises and hi stays 0.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_NE   = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             shift_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  // Zero-extended add/sub: the extra top bit is carry-out / borrow.
  assign add_ext = {1'b0, bus.d} + {1'b0, bus.c};
  assign sub_ext = {1'b0, bus.d} - {1'b0, bus.c};

  // Signed overflow: same-sign inputs flipping (add), or opposite-sign
  // inputs where the result sign differs from d (sub).
  assign add_ovf = (bus.d[WIDTH-1] == bus.c[WIDTH-1]) &&
                   (add_ext[WIDTH-1] != bus.d[WIDTH-1]);
  assign sub_ovf = (bus.d[WIDTH-1] != bus.c[WIDTH-1]) &&
                   (sub_ext[WIDTH-1] != bus.d[WIDTH-1]);

  // The whole of c is the shift amount; anything >= WIDTH shifts everything out.
  assign shift_big = 32'(bus.c) >= WIDTH;

  // Result and flag selection for every single-cycle opcode.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    alu_res   = add_ext[WIDTH-1:0];
    alu_carry = add_ext[WIDTH];
    alu_ovf   = add_ovf;
    case (bus.alu_control)
      OP_ADD: ;
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
        alu_ovf   = sub_ovf;
      end
      OP_AND: begin
        alu_res   = bus.d & bus.c;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
      OP_NOR: begin
        alu_res   = ~(bus.d | bus.c);
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
      OP_SHL: begin
        alu_res   = shift_big ? '0 : (bus.d << bus.c);
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
      OP_SHR: begin
        alu_res   = shift_big ? '0 : (bus.d >> bus.c);
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
      OP_SRA: begin
        alu_res   = shift_big ? {WIDTH{bus.d[WIDTH-1]}}
                              : WIDTH'($signed(bus.d) >>> bus.c);
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
      OP_SLTU: begin
        alu_res    = '0;
        alu_res[0] = sub_ext[WIDTH];
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
      end
      OP_NE: begin
        alu_res    = '0;
        alu_res[0] = (bus.d != bus.c);
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
      end
      default: ;  // includes 0100 when it is not handled by the multiplier
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative multiplier and control
  // ---------------------------------------------------------------------
  logic single_go;

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] p_next;
  logic               mul_last;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift {sum, p_lo} right by one.
  assign step_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign p_next   = {step_sum, p_lo[WIDTH-1:1]};
  assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));

  // Requests are taken only in IDLE; 0100 is diverted to the multiplier.
  assign single_go = bus.start && (state == S_IDLE) && (bus.alu_control != OP_MUL);
  assign bus.busy  = (state == S_MUL);

  // FSM and multiplier registers: latch operands on accept, iterate in MUL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.alu_control == OP_MUL)) begin
            mcand <= bus.d;
            p_hi  <= '0;
            p_lo  <= bus.c;
            cnt   <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          p_hi <= p_next[2*WIDTH-1:WIDTH];
          p_lo <= p_next[WIDTH-1:0];
          cnt  <= cnt + 1'b1;
          if (mul_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  // No multiplier: every accepted request completes in one cycle.
  assign single_go = bus.start;
  assign bus.busy  = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Result and flag registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] hi_q;
  logic             carry_q;
  logic             ovf_q;
  logic             done_q;

  // Results update only when an operation completes; done pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      done_q <= 1'b0;
      if (single_go) begin
        acc_q   <= alu_res;
        hi_q    <= '0;
        carry_q <= alu_carry;
        ovf_q   <= alu_ovf;
        done_q  <= 1'b1;
      end
`ifdef ALU_MUL_EN
      else if (mul_last) begin
        acc_q   <= p_next[WIDTH-1:0];
        hi_q    <= p_next[2*WIDTH-1:WIDTH];
        carry_q <= |p_next[2*WIDTH-1:WIDTH];
        ovf_q   <= 1'b0;
        done_q  <= 1'b1;
      end
`endif
    end
  end

  assign bus.acc      = acc_q;
  assign bus.hi       = hi_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
  assign bus.status   = (acc_q == '0);
  assign bus.negative = acc_q[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=8): the stimulus process pushes the
// hand-computed result of every accepted request, and a monitor pops and
// compares on each done pulse, including the cycle in which done appears.
module tb_alu_mc;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] acc;
    logic [W-1:0] hi;
    logic         carry;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] c;
    logic [W-1:0] acc;
    logic         carry;
    logic         ovf;
  } vec_t;

  // Directed single-cycle vectors with hand-computed results (hi is always 0).
  localparam int NV = 19;
  localparam vec_t VECS [NV] = '{
    '{4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},  // add wraps to zero
    '{4'b0001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},  // sub signed overflow
    '{4'b0001, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0},  // sub borrow
    '{4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0},  // and
    '{4'b0011, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0},  // nor
    '{4'b1100, 8'h01, 8'h09, 8'h00, 1'b0, 1'b0},  // shl by >= WIDTH
    '{4'b1100, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0},  // shl drops msb
    '{4'b1101, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0},  // shr logical
    '{4'b1110, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0},  // sra sign fill
    '{4'b1110, 8'h80, 8'hC8, 8'hFF, 1'b0, 1'b0},  // sra by 200
    '{4'b1101, 8'h80, 8'h08, 8'h00, 1'b0, 1'b0},  // shr by exactly WIDTH
    '{4'b1011, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0},  // sltu true
    '{4'b1011, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0},  // sltu false
    '{4'b1010, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0},  // ne false
    '{4'b1010, 8'h05, 8'h06, 8'h01, 1'b0, 1'b0},  // ne true
    '{4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},  // add signed overflow
    '{4'b1111, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0},  // undefined code -> add
    '{4'b0001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0},  // sub equal
    '{4'b0111, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0}   // undefined code -> add
  };

  exp_t sb [$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Rising-edge counter used to pin down the cycle each done must appear in.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("acc",        bus.acc,      mon_e.acc);
        check("hi",         bus.hi,       mon_e.hi);
        check("status",     bus.status,   mon_e.acc == '0);
        check("carry",      bus.carry,    mon_e.carry);
        check("overflow",   bus.overflow, mon_e.ovf);
        check("negative",   bus.negative, mon_e.acc[W-1]);
        check("done_cycle", cyc,          mon_e.done_cyc);
      end
    end
  end

  // Issue one request starting at a falling edge; returns at the next one.
  // lat is the number of edges between acceptance and the completing edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] d, input logic [W-1:0] c,
                       input logic push, input logic [W-1:0] e_acc, input logic [W-1:0] e_hi,
                       input logic e_carry, input logic e_ovf, input int lat);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("busy_timeout", 64'd1, 64'd0);
    bus.alu_control = op;
    bus.d           = d;
    bus.c           = c;
    bus.start       = 1'b1;
    if (push) begin
      exp_t e;
      e.acc      = e_acc;
      e.hi       = e_hi;
      e.carry    = e_carry;
      e.ovf      = e_ovf;
      e.done_cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.d           = '0;
    bus.c           = '0;
    bus.alu_control = 4'b0000;
    #1;
    check("rst_acc",      bus.acc,      8'h00);
    check("rst_hi",       bus.hi,       8'h00);
    check("rst_status",   bus.status,   1'b1);
    check("rst_carry",    bus.carry,    1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_negative", bus.negative, 1'b0);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_done",     bus.done,     1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back single-cycle vectors.
    for (int i = 0; i < NV; i++)
      issue(VECS[i].op, VECS[i].d, VECS[i].c, 1'b1,
            VECS[i].acc, 8'h00, VECS[i].carry, VECS[i].ovf, 0);
    drain();

    // Code 0100 with d=3, c=4.
`ifdef ALU_MUL_EN
    issue(4'b0100, 8'h03, 8'h04, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, W);
    check("mul_busy_high", bus.busy, 1'b1);
`else
    issue(4'b0100, 8'h03, 8'h04, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0, 0);
    check("op0100_busy_low", bus.busy, 1'b0);
    check("op0100_hi_zero",  bus.hi,   8'h00);
`endif
    drain();

`ifdef ALU_MUL_EN
    // 0xFF*0xFF: busy for W cycles, start pulses (one on the completing
    // edge) and operand changes during MUL must be ignored.
    issue(4'b0100, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'hFE, 1'b1, 1'b0, W);
    for (int i = 1; i <= W; i++) begin
      check("mul_busy", bus.busy, 1'b1);
      bus.alu_control = 4'b0000;
      bus.d           = 8'h01;
      bus.c           = 8'h01;
      bus.start       = (i == 3 || i == W);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("mul_busy_end", bus.busy, 1'b0);
    @(negedge clk);
    check("mul_single_done", bus.done, 1'b0);
    drain();
`endif

    // Leave a nonzero result in place, then reset in the middle of a cycle.
    issue(4'b0000, 8'h10, 8'h20, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 0);
    drain();
`ifdef ALU_MUL_EN
    issue(4'b0100, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, W);
`endif
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_acc",    bus.acc,    8'h00);
    check("abort_hi",     bus.hi,     8'h00);
    check("abort_busy",   bus.busy,   1'b0);
    check("abort_done",   bus.done,   1'b0);
    check("abort_status", bus.status, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    issue(4'b0000, 8'h02, 8'h03, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 0);
    drain();

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_acc",  bus.acc,  8'h05);
    check("hold_done", bus.done, 1'b0);
    check("sb_empty",  sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: start  input  1  request; sampled only when busy=0.
REQ-005 SHALL provide port: c  input  WIDTH  operand c (second operand / shift amount).
REQ-006 SHALL provide port: d  input  WIDTH  operand d (first operand).
REQ-007 SHALL provide port: alu_control  input  4  operation select.
REQ-008 SHALL provide port: acc  output  WIDTH  registered result (low half for multiply).
REQ-009 SHALL provide port: hi  output  WIDTH  registered upper half of multiply; 0 after every other op.
REQ-010 SHALL provide port: status  output  1  zero flag, 1 when acc==0, derived combinationally from acc.
REQ-011 SHALL provide port: carry  output  1  registered carry/borrow flag.
REQ-012 SHALL provide port: overflow  output  1  registered signed-overflow flag.
REQ-013 SHALL provide port: negative  output  1  equals acc[WIDTH-1].
REQ-014 SHALL provide port: busy  output  1  high while a multi-cycle op is in progress.
REQ-015 SHALL provide port: done  output  1  one-cycle pulse, result and flags valid.

Function
REQ-016 SHALL decode: 0000 d+c; 0001 d-c; 0010 d&c; 0011 ~(d|c); 1100 d<<c; 1101 d>>c logical; 1110 d>>>c arithmetic; 1011 (d<c unsigned)?1:0; 1010 (d!=c)?1:0; 0100 d*c unsigned; any other code d+c.
REQ-017 SHALL implement states IDLE and MUL only; busy=1 exactly when in MUL.
REQ-018 SHALL, for a single-cycle op, accept start=1 in IDLE at edge N, write acc/hi/flags at edge N, assert done for the cycle after edge N, remain in IDLE.
REQ-019 SHALL, for 0100, latch d and c at accepting edge N, enter MUL, perform one shift-add iteration per edge, write {hi,acc} = full 2*WIDTH product and assert done after edge N+WIDTH, then return to IDLE.
REQ-020 SHALL ignore start while busy=1, including at the completing edge N+WIDTH; earliest next acceptance is edge N+WIDTH+1.
REQ-021 SHALL hold acc, hi and all flags unchanged when no operation completes; done=0 otherwise.
REQ-022 SHALL use the full value of c as shift amount; c>=WIDTH yields 0 for 1100/1101 and WIDTH copies of d[WIDTH-1] for 1110.
REQ-023 SHALL set carry = carry-out for add, = borrow (d<c unsigned) for sub, = (hi!=0) for multiply, 0 for all other ops.
REQ-024 SHALL set overflow = two's-complement overflow for add and sub, 0 for all other ops.
REQ-025 SHALL ignore changes to d, c, alu_control during MUL (latched copies used).

Reset
REQ-026 SHALL on rst=1, immediately and regardless of clk: state IDLE, iteration counter 0, acc=0, hi=0, carry=0, overflow=0, done=0, busy=0; hence status=1, negative=0.
REQ-027 SHALL abort any multiply in progress on reset with no done pulse; the first rising edge after rst deasserts SHALL accept a start.

Configuration
REQ-028 SHALL compile the iterative multiplier only when macro ALU_MUL_EN is defined.
REQ-029 SHALL, without ALU_MUL_EN, treat code 0100 as the default add (single-cycle), never assert busy, and keep hi at 0 permanently.

Verification
REQ-030 SHALL cover (WIDTH=8): add d=0xFF c=0x01 -> acc=0x00, status=1, carry=1, overflow=0, done one cycle after accept.
REQ-031 SHALL cover: sub d=0x80 c=0x01 -> acc=0x7F, overflow=1, carry=0, negative=0; sub d=0x01 c=0x02 -> acc=0xFF, carry=1, negative=1.
REQ-032 SHALL cover (ALU_MUL_EN): mul d=0xFF c=0xFF -> busy 8 cycles, start pulsed during busy ignored, then hi=0xFE, acc=0x01, carry=1, single done pulse.
REQ-033 SHALL cover: sra d=0x80 c=3 -> acc=0xF0; shl d=0x01 c=9 -> acc=0x00, status=1; sra d=0x80 c=200 -> acc=0xFF.
REQ-034 SHALL cover: rst asserted mid-cycle 4 of mul d=0x12 c=0x34 -> acc=0, hi=0, busy=0 immediately, no done; next start add 2+3 -> acc=0x05.
REQ-035 SHALL cover (no ALU_MUL_EN): code 0100 d=0x03 c=0x04 -> acc=0x07 single-cycle, busy stays 0, hi=0.
